// File: rtl/pe_sa_pkg.sv
// Shared definitions for the approximate systolic-array PE controller and
// its PE wrapper: default widths, PE pipeline latency and the FSM state type.
package pe_sa_pkg;

  localparam int DW     = 16;
  localparam int AW     = 8;
  localparam int PE_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pe_sa_issue_timer.sv
// Issue pacing for one PE controller. A modulo-PE_LAT down-counter paces the
// buffer reads, and a second counter tracks how long the current operand pair
// must stay presented to the PE.
module pe_sa_issue_timer #(
  parameter int PE_LAT = pe_sa_pkg::PE_LAT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_run,
  input  logic i_opLoad,
  output logic o_issue,
  output logic o_hold,
  output logic o_holdNext
);

  localparam int CW = $clog2(PE_LAT + 1);

  logic [CW-1:0] r_issueCnt;
  logic [CW-1:0] r_holdCnt;

  // Issue phase: zero means "read this cycle", then reload to space reads PE_LAT apart
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_issueCnt <= '0;
    end else if (i_clear) begin
      r_issueCnt <= '0;
    end else if (i_run) begin
      if (r_issueCnt == '0) begin
        r_issueCnt <= CW'(PE_LAT - 1);
      end else begin
        r_issueCnt <= r_issueCnt - CW'(1);
      end
    end
  end

  // Operand hold: counts down the PE_LAT cycles a freshly loaded pair stays visible
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_holdCnt <= '0;
    end else if (i_opLoad) begin
      r_holdCnt <= CW'(PE_LAT);
    end else if (r_holdCnt != '0) begin
      r_holdCnt <= r_holdCnt - CW'(1);
    end
  end

  // Strobes derived from the two counters
  always_comb begin
    o_issue    = i_run && (r_issueCnt == '0);
    o_hold     = (r_holdCnt != '0);
    o_holdNext = (r_holdCnt != '0) && (r_holdCnt != CW'(1));
  end

endmodule

// File: rtl/pe_approx_sa_ctrl.sv
// Sequencer for one approximate systolic-array PE. Streams len operand pairs
// from the local buffers into the PE, chains the PE's partial sum back as the
// next ipsum, and returns the final sum through a valid/ready handshake.
module pe_approx_sa_ctrl #(
  parameter int DW     = pe_sa_pkg::DW,
  parameter int AW     = pe_sa_pkg::AW,
  parameter int PE_LAT = pe_sa_pkg::PE_LAT
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [AW-1:0] i_len,
  input  logic [AW-1:0] i_ifmapBase,
  input  logic [AW-1:0] i_weightBase,
  input  logic [DW-1:0] i_ipsumInit,
  output logic          o_bufRdEn,
  output logic [AW-1:0] o_ifmapRdAddr,
  output logic [AW-1:0] o_weightRdAddr,
  input  logic [DW-1:0] i_ifmapRdData,
  input  logic [DW-1:0] i_weightRdData,
  output logic [DW-1:0] o_peIfmap,
  output logic [DW-1:0] o_peWeight,
  output logic [DW-1:0] o_peIpsum,
  input  logic [DW-1:0] i_pePsum,
  output logic          o_busy,
  output logic [DW-1:0] o_result,
  output logic          o_resultValid,
  input  logic          i_resultReady
);

  import pe_sa_pkg::*;

  state_t        r_state;
  state_t        w_nextState;
  logic [AW-1:0] r_len;
  logic [AW-1:0] r_ifBase;
  logic [AW-1:0] r_wtBase;
  logic [AW-1:0] r_k;
  logic [DW-1:0] r_init;
  logic [DW-1:0] r_result;
  logic [DW-1:0] r_peIfmap;
  logic [DW-1:0] r_peWeight;
  logic          r_rdValid;
  logic          r_rdFirst;
  logic          r_opFirst;
  logic          w_accept;
  logic          w_issue;
  logic          w_hold;
  logic          w_holdNext;
  logic          w_lastIssue;
  logic          w_capture;

  assign w_accept    = (r_state == IDLE) && i_start;
  assign w_lastIssue = w_issue && (r_k == r_len - AW'(1));
  assign w_capture   = (r_state == DRAIN) && !r_rdValid && !w_hold;

  pe_sa_issue_timer #(
    .PE_LAT(PE_LAT)
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (w_accept),
    .i_run      (r_state == RUN),
    .i_opLoad   (r_rdValid),
    .o_issue    (w_issue),
    .o_hold     (w_hold),
    .o_holdNext (w_holdNext)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; a zero-length job skips straight to DONE
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_start) w_nextState = (i_len == '0) ? DONE : RUN;
      RUN:     if (w_lastIssue) w_nextState = DRAIN;
      DRAIN:   if (w_capture) w_nextState = DONE;
      DONE:    if (i_resultReady) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Outputs: addresses only driven while issuing, ipsum chained from the PE after term 0
  always_comb begin
    o_busy         = (r_state != IDLE);
    o_resultValid  = (r_state == DONE);
    o_bufRdEn      = w_issue;
    o_ifmapRdAddr  = w_issue ? (r_ifBase + r_k) : '0;
    o_weightRdAddr = w_issue ? (r_wtBase + r_k) : '0;
    o_peIfmap      = r_peIfmap;
    o_peWeight     = r_peWeight;
    o_peIpsum      = '0;
    if (w_hold) begin
      o_peIpsum = r_opFirst ? r_init : i_pePsum;
    end
    o_result       = r_result;
  end

  // Job parameters, term counter and final result capture
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_len    <= '0;
      r_ifBase <= '0;
      r_wtBase <= '0;
      r_init   <= '0;
      r_k      <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_len    <= i_len;
        r_ifBase <= i_ifmapBase;
        r_wtBase <= i_weightBase;
        r_init   <= i_ipsumInit;
        r_k      <= '0;
        if (i_len == '0) begin
          r_result <= i_ipsumInit;
        end
      end else if (w_issue) begin
        r_k <= r_k + AW'(1);
      end
      if (w_capture) begin
        r_result <= i_pePsum;
      end
    end
  end

  // Operand registers: load the cycle after a read, hold PE_LAT cycles, else zero
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rdValid  <= 1'b0;
      r_rdFirst  <= 1'b0;
      r_opFirst  <= 1'b0;
      r_peIfmap  <= '0;
      r_peWeight <= '0;
    end else begin
      r_rdValid <= w_issue;
      r_rdFirst <= w_issue && (r_k == '0);
      if (r_rdValid) begin
        r_peIfmap  <= i_ifmapRdData;
        r_peWeight <= i_weightRdData;
        r_opFirst  <= r_rdFirst;
      end else if (!w_holdNext) begin
        r_peIfmap  <= '0;
        r_peWeight <= '0;
        r_opFirst  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pe_approx_sa_ctrl.md
# pe_approx_sa_ctrl

Sequencer for one approximate systolic-array processing element. On `start` it performs a length-`len` dot product. It fetches ifmap/weight operand pairs from two local read-only buffers and drives them into the PE one term at a time. It feeds the PE's registered partial sum back as the next `ipsum`, then returns the final sum through a valid/ready handshake. It sits between the tile's operand SRAMs and a PE instance, one controller per PE.

## Interface
- `DW`, 16, operand and partial-sum width.
- `AW`, 8, buffer address width; also the width of `len`.
- `PE_LAT`, 1, cycles from a PE input change to the matching registered `psum`; also the term issue interval.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  AW  number of MAC terms; 0 is legal.
- `ifmap_base`, `weight_base`  in  AW each  first buffer addresses.
- `ipsum_init`  in  DW  initial partial sum, captured at start.
- `buf_rd_en`  out  1  read strobe to both buffers.
- `ifmap_rd_addr`, `weight_rd_addr`  out  AW each  buffer addresses.
- `ifmap_rd_data`, `weight_rd_data`  in  DW each  valid the cycle after `buf_rd_en`.
- `pe_ifmap`, `pe_weight`, `pe_ipsum`  out  DW each  PE operand inputs.
- `pe_psum`  in  DW  PE registered partial sum.
- `busy`  out  1  high in any state other than IDLE.
- `result`  out  DW  final partial sum.
- `result_valid`  out  1  result held until accepted.
- `result_ready`  in  1  consumer accept.

## Operation
- The controller has four states.
  - IDLE to RUN on `start`. The same edge captures `len`, both bases and `ipsum_init`, and clears the term counter `k`.
  - IDLE to DONE directly if `start` arrives with `len` = 0. In that case `result` = `ipsum_init`.
  - RUN: issue address `base + k` with `buf_rd_en` = 1 for one cycle every `PE_LAT` cycles. Go to DRAIN after issuing term `len-1`.
  - DRAIN: wait until the last term's `psum` is valid, capture it into `result`, then go to DONE.
  - DONE: `result_valid` = 1. Go to IDLE on the cycle `result_valid & result_ready`.
- `start` is ignored while `busy`.
- Addresses wrap modulo 2^AW.
- Operand registers:
  - `pe_ifmap`/`pe_weight` load from rd_data on the cycle after each read.
  - They hold for `PE_LAT` cycles.
  - They are zero outside active terms, so the PE accumulates nothing spurious.
- `pe_ipsum` mux: term 0 uses the captured `ipsum_init`. Term k>0 uses `pe_psum`, which is the PE output for term k-1.
- Width rule: no arithmetic is performed in the controller apart from the counter and address adders. Sum precision and approximation are entirely the PE's.
- Back-pressure: DONE holds `result` stable indefinitely. No new job is accepted until the handshake completes.
- Reset: synchronous, with priority over all else, mid-job included. It forces IDLE, and every output, `k` and the operand registers go to 0. `result_valid` = 0 and `busy` = 0 on the cycle after reset is sampled.

## Timing
- Let cycle c0 be the cycle in which `start` is sampled.
- Term k read is issued in cycle c1 + k·PE_LAT.
- The PE sees term k in cycles c3 + k·PE_LAT through c3 + (k+1)·PE_LAT − 1.
- `pe_psum` for term k is valid in cycle c3 + (k+1)·PE_LAT.
- `result_valid` rises in cycle c4 + len·PE_LAT. Latency is len·PE_LAT + 4 cycles.
- For `len` = 0, `result_valid` rises in c1.
- `busy` rises in c1 and falls in the cycle after the accepting handshake.
- Back-to-back jobs: `start` may be high in the first IDLE cycle after the handshake. There is a minimum 1 idle cycle between jobs.

## Structure
- Shared package `pe_sa_pkg`:
  - state enum (IDLE, RUN, DRAIN, DONE).
  - DW/AW defaults.
  - the PE_LAT constant, shared with the PE wrapper.
- One natural sub-module, `pe_sa_issue_timer`. It is a modulo-PE_LAT down-counter producing the issue strobe and the operand-hold enable. Everything else stays in the FSM.

## Test plan
- Bench uses an exact PE stub, `psum <= ipsum + (ifmap*weight)[DW-1:0]` with PE_LAT cycles. The approximate PE is swapped in only for integration.
- Single job: PE_LAT=1, len=3, ifmap {1,2,3}, weight {4,5,6}, ipsum_init 0 → result 32, `result_valid` in c0+7, addresses base..base+2 each issued once.
- Init and wrap: len=2, ifmap_base=8'hFF, ipsum_init 100, operands {2,3}×{10,10} → addresses FF then 00, result 150.
- len=0, ipsum_init 16'h1234 → no `buf_rd_en`, `result_valid` in c1 with result 16'h1234.
- Back-pressure: hold `result_ready`=0 for 10 cycles → result stable, `busy`=1, extra `start` pulses ignored. Release → IDLE next cycle, then a new job runs correctly.
- PE_LAT=3, len=4, all operands 1, init 0 → reads spaced 3 cycles apart, result 4 at c0+16.
- Reset mid-RUN (term 2 of 5) → next cycle every output is 0 and the FSM is IDLE. A subsequent job gives the correct result with no residue.
